// File: rtl/pc_pkg.sv
// Shared defaults and next-PC select encoding for the PC / return-address-stack unit.
package pc_pkg;

  localparam int unsigned PC_W_DEF      = 6;
  localparam int unsigned IMM_W_DEF     = 6;
  localparam int unsigned RAS_DEPTH_DEF = 4;
  localparam int unsigned RESET_VEC_DEF = 0;

  typedef enum logic [2:0] {
    SEL_INC  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JUMP = 3'd2,
    SEL_CALL = 3'd3,
    SEL_RET  = 3'd4
  } next_sel_e;

endpackage

// File: rtl/pc_ras_unit_if.sv
// Control-unit <-> PC unit bus: control inputs in, PC and stack status out.
interface pc_ras_unit_if
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned IMM_W     = IMM_W_DEF,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) ();

  logic                        halt;
  logic                        stall;
  logic                        branch;
  logic                        zero;
  logic                        jump;
  logic                        call;
  logic                        ret;
  logic [IMM_W-1:0]            imm_branch;
  logic [PC_W-1:0]             jump_addr;
  logic [PC_W-1:0]             pc;
  logic [PC_W-1:0]             pc_plus1;
  logic [$clog2(RAS_DEPTH):0]  ras_count;
  logic                        ras_overflow;
  logic                        ras_underflow;

  modport master (
    output halt, stall, branch, zero, jump, call, ret, imm_branch, jump_addr,
    input  pc, pc_plus1, ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  halt, stall, branch, zero, jump, call, ret, imm_branch, jump_addr,
    output pc, pc_plus1, ras_count, ras_overflow, ras_underflow
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty only raises the sticky underflow flag.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [PC_W-1:0]            push_data,
  output logic [PC_W-1:0]            top_data,
  output logic [$clog2(RAS_DEPTH):0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [PTR_W-1:0] wr_ptr;
  logic             wr_en;
  logic [PC_W-1:0]  mem_q [RAS_DEPTH];

  // Pop has priority; pointer wraps naturally since depth is a power of two.
  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_ptr  = top_q + PTR_W'(1);
    if (pop) begin
      if (count_q != CNT_W'(0)) begin
        top_d   = top_q - PTR_W'(1);
        count_d = count_q - CNT_W'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (push) begin
      wr_en = 1'b1;
      top_d = wr_ptr;
      if (count_q == CNT_W'(RAS_DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entries carry no reset; an empty stack is never selected onto pc.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= push_data;
    end
  end

  assign top_data  = mem_q[top_q];
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: rtl/pc_ras_unit.sv
// Program counter with signed branches, jumps and call/return via a circular RAS.
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned IMM_W     = IMM_W_DEF,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF,
  parameter int unsigned RESET_VEC = RESET_VEC_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  pc_ras_unit_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  br_off;
  logic [PC_W-1:0]  top_data;
  logic [CNT_W-1:0] ras_count;
  logic             hold;
  logic             push;
  logic             pop;
  next_sel_e        sel;

  assign hold   = bus.halt | bus.stall;
  assign pc_inc = pc_q + PC_W'(1);
  assign br_off = PC_W'($signed(bus.imm_branch));
  assign push   = ~hold & bus.call & ~bus.ret;
  assign pop    = ~hold & bus.ret;

  // Priority: ret, call, jump, taken branch, increment; an empty-stack ret falls through to pc+1.
  always_comb begin
    sel = SEL_INC;
    if (bus.ret) begin
      sel = (ras_count != CNT_W'(0)) ? SEL_RET : SEL_INC;
    end else if (bus.call) begin
      sel = SEL_CALL;
    end else if (bus.jump) begin
      sel = SEL_JUMP;
    end else if (bus.branch && bus.zero) begin
      sel = SEL_BR;
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (!hold) begin
      unique case (sel)
        SEL_RET:  pc_d = top_data;
        SEL_CALL: pc_d = bus.jump_addr;
        SEL_JUMP: pc_d = bus.jump_addr;
        SEL_BR:   pc_d = pc_inc + br_off;
        default:  pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= PC_W'(RESET_VEC);
    end else begin
      pc_q <= pc_d;
    end
  end

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top_data  (top_data),
    .count     (ras_count),
    .overflow  (bus.ras_overflow),
    .underflow (bus.ras_underflow)
  );

  assign bus.pc        = pc_q;
  assign bus.pc_plus1  = pc_inc;
  assign bus.ras_count = ras_count;

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
- Parametrised successor to the single-cycle program counter. Computes and registers the next instruction address each cycle.
- Adds over the previous PC:
  - signed branch offsets
  - call/return instructions backed by a circular return-address stack (RAS)
  - a stall input separate from halt
  - sticky stack-error flags
- Sits between the control unit/ALU-zero logic and instruction memory in the MIPS-style core.

Parameters:
- PC_W, 6, width of the PC and of all addresses.
- IMM_W, 6, width of the branch immediate; sign-extended to PC_W. Requires IMM_W <= PC_W.
- RAS_DEPTH, 4, number of return-address entries. Must be >= 2 and a power of two.
- RESET_VEC, 0, PC value loaded on reset (PC_W bits).

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- halt  in  1  freeze PC and RAS (level).
- stall  in  1  freeze PC and RAS for this cycle (pipeline hazard).
- branch  in  1  conditional branch instruction.
- zero  in  1  ALU zero flag; branch taken when branch & zero.
- jump  in  1  unconditional jump to jump_addr.
- call  in  1  jump to jump_addr and push pc+1.
- ret  in  1  pop RAS and jump to popped address.
- imm_branch  in  IMM_W  signed two's-complement branch offset.
- jump_addr  in  PC_W  absolute jump/call target.
- pc  out  PC_W  current PC (registered).
- pc_plus1  out  PC_W  pc+1 mod 2^PC_W (combinational; link value).
- ras_count  out  clog2(RAS_DEPTH)+1  valid entries in RAS.
- ras_overflow  out  1  sticky: a push occurred while full.
- ras_underflow  out  1  sticky: a pop occurred while empty.

Behaviour:
- Reset (async, reset_n=0): pc=RESET_VEC, ras_count=0, top pointer=0, flags=0. RAS contents are don't-care. Reset takes effect immediately, mid-instruction included. Release is synchronous to the next clk edge.
- Hold: halt=1 or stall=1 -> pc, RAS, count and flags all hold. All control inputs are ignored that cycle; none of them is queued.
- Next-PC priority (highest first): ret, call, jump, branch-taken, pc+1.
- ret with ras_count>0:
  - next pc = stack top;
  - top pointer decrements, modulo RAS_DEPTH;
  - ras_count decrements.
- ret with ras_count=0:
  - next pc = pc+1;
  - ras_underflow set;
  - pointer and count unchanged.
- call:
  - push pc_plus1 at top+1 (mod RAS_DEPTH); top advances;
  - next pc = jump_addr.
  - If ras_count was RAS_DEPTH: oldest entry is overwritten (circular), count stays RAS_DEPTH, ras_overflow set.
- jump: next pc = jump_addr. RAS untouched.
- branch taken: next pc = pc+1+sext(imm_branch), all mod 2^PC_W.
- All address arithmetic wraps silently modulo 2^PC_W; no carry or flag.
- ret and call asserted together: ret wins; no push occurs. Same rule for any lower-priority input combined with ret or call.
- Latency: a control decision at edge N is visible on pc after edge N. A popped address is available the cycle after ret.
- Sticky flags clear only on reset.
- RAS storage: plain registers, no reset required on entries. A read from an empty stack never reaches pc.

Decomposition:
- Shared package pc_pkg holds:
  - PC_W/IMM_W defaults;
  - next-PC select encoding (SEL_RET, SEL_CALL, SEL_JUMP, SEL_BR, SEL_INC);
  - RESET_VEC default.
- Sub-module pc_ras: circular return-address stack.
  - Inputs: push, pop, push_data.
  - Outputs: top_data, count, overflow, underflow.
  - Parametrised by PC_W and RAS_DEPTH.
- Top level holds the next-PC mux and the pc register.

Test Plan:
- Reset/increment: reset_n low then high, no controls for 70 cycles -> pc 0,1,..,63,0,1,...; wraps 63->0 with no flag.
- Signed branch: pc=10, branch=1, zero=1, imm_branch=6'b111100 (-4) -> pc=7. Same with zero=0 -> pc=11.
- Nested call/ret:
  - pc=5, call to 20 -> pc=20, count=1;
  - call at 20 to 40 -> pc=40, count=2;
  - ret -> pc=21;
  - ret -> pc=6, count=0;
  - flags stay 0.
- Overflow: five calls from pcs 1,11,21,31,41 (targets 11,21,31,41,50) with RAS_DEPTH=4 -> count=4, ras_overflow=1. Four rets -> pc 42,32,22,12; count=0.
- Underflow and priority:
  - ret with empty RAS at pc=9 -> pc=10, ras_underflow=1.
  - ret+call together with RAS holding 30 -> pc=30, no push.
- Stall/halt/reset: call asserted with stall=1 -> pc and count unchanged.
  - halt=1 for 3 cycles -> pc constant.
  - reset_n pulsed low between clock edges while count=3 -> pc=0, count=0 immediately.
